// File: rtl/riscv_core_mul_pkg.sv
// Shared types and iteration-count helpers for the radix-4 Booth multiplier.
package riscv_core_mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int unsigned WORD_BITS = 32;

  // Operands carry two extension bits, so a full op retires (XLEN+2)/2 digits.
  function automatic int unsigned booth_iters(input int unsigned xlen);
    return (xlen + 2) / 2;
  endfunction

  function automatic int unsigned booth_word_iters();
    return (WORD_BITS + 2) / 2;
  endfunction

endpackage

// File: rtl/riscv_core_booth4_enc.sv
// Radix-4 Booth digit decoder: window -> {zero, neg, two}, plus the 0/+M/~M select.
// Doubling and the +1 that completes negation are applied by the caller.
module riscv_core_booth4_enc
  import riscv_core_mul_pkg::*;
#(
  parameter int W = 66
) (
  input  logic [2:0]   i_win,
  input  logic [W-1:0] i_mcand,
  output logic         o_zero,
  output logic         o_neg,
  output logic         o_two,
  output logic [W+1:0] o_pp
);

  logic [W+1:0] mag;

  always_comb begin
    o_zero = (i_win == 3'b000) || (i_win == 3'b111);
    o_two  = (i_win == 3'b011) || (i_win == 3'b100);
    o_neg  = i_win[2] && !o_zero;
    mag    = {{2{i_mcand[W-1]}}, i_mcand};
    if (o_zero) begin
      o_pp = '0;
    end else if (o_neg) begin
      o_pp = ~mag;
    end else begin
      o_pp = mag;
    end
  end

endmodule

// File: rtl/riscv_core_mul_booth4.sv
// Iterative radix-4 Booth multiplier for RV M-extension ops (MUL/MULH/MULHSU/MULHU, *W).
// One Booth digit per cycle; a single op in flight; result held until consumed.
module riscv_core_mul_booth4
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int W_EN = 1
) (
  input  logic            i_booth_clk,
  input  logic            i_booth_rstn,
  input  logic            i_booth_valid,
  output logic            o_booth_ready,
  input  logic [1:0]      i_booth_op,
  input  logic            i_booth_word,
  input  logic [XLEN-1:0] i_booth_rs1,
  input  logic [XLEN-1:0] i_booth_rs2,
  input  logic            i_booth_kill,
  output logic            o_booth_valid,
  input  logic            i_booth_res_ready,
  output logic [XLEN-1:0] o_booth_result,
  output logic            o_booth_busy,
  output logic [1:0]      o_booth_dbg_state
);

  localparam int          OPW        = XLEN + 2;
  localparam int          ACC_W      = XLEN + 4;
  localparam int unsigned FULL_ITERS = booth_iters(XLEN);
  localparam int unsigned WORD_ITERS = booth_word_iters();
  localparam int          CNT_W      = $clog2(FULL_ITERS + 1);
  localparam bit          WORD_OK    = (XLEN == 64) && (W_EN != 0);

  mul_state_e       state_q, state_d;
  logic             alive_q, alive_d;
  mul_op_e          op_q, op_d;
  logic             word_q, word_d;
  logic [OPW-1:0]   mcand_q, mcand_d;
  logic [OPW-1:0]   mplr_q, mplr_d;
  logic             guard_q, guard_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             word_in, rs1_signed, rs2_signed;
  mul_op_e          op_in;
  logic             booth_zero, booth_neg, booth_two;
  logic [ACC_W-1:0] pp_m, pp, sum;
  logic [XLEN-1:0]  word_res, result_sel;

  // Handshakes: a request transfers on a rising edge where i_booth_valid && o_booth_ready
  // and no kill; a result transfers on an edge where o_booth_valid && i_booth_res_ready.
  assign o_booth_ready     = alive_q && (state_q == ST_IDLE);
  assign o_booth_busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign o_booth_valid     = (state_q == ST_DONE) && !i_booth_kill;
  assign o_booth_result    = o_booth_valid ? result_q : '0;
  assign o_booth_dbg_state = state_q;

  // Word ops are always MUL and extend both operands from bit 31.
  always_comb begin
    word_in    = i_booth_word && WORD_OK;
    op_in      = word_in ? MUL_OP_MUL : mul_op_e'(i_booth_op);
    rs1_signed = (op_in == MUL_OP_MULH) || (op_in == MUL_OP_MULHSU);
    rs2_signed = (op_in == MUL_OP_MULH);
  end

  riscv_core_booth4_enc #(.W(OPW)) u_enc (
    .i_win   ({mplr_q[1:0], guard_q}),
    .i_mcand (mcand_q),
    .o_zero  (booth_zero),
    .o_neg   (booth_neg),
    .o_two   (booth_two),
    .o_pp    (pp_m)
  );

  // pp_m is one's-complement when negative; shifting in neg keeps that form for -2M,
  // and the carry-in of neg completes the two's complement.
  always_comb begin
    pp  = booth_two ? {pp_m[ACC_W-2:0], booth_neg} : pp_m;
    sum = booth_zero ? acc_q : acc_q + pp + ACC_W'(booth_neg);
  end

  // Low product bits land at the top of mplr; after 17 word iterations
  // product[31:0] sits at mplr[XLEN-1 -: 32].
  always_comb begin
    word_res       = {XLEN{mplr_q[XLEN-1]}};
    word_res[31:0] = mplr_q[XLEN-1 -: 32];
    if (word_q) begin
      result_sel = word_res;
    end else if (op_q == MUL_OP_MUL) begin
      result_sel = mplr_q[XLEN-1:0];
    end else begin
      result_sel = {acc_q[XLEN-3:0], mplr_q[OPW-1:XLEN]};
    end
  end

  always_comb begin
    state_d  = state_q;
    alive_d  = 1'b1;
    op_d     = op_q;
    word_d   = word_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    guard_d  = guard_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (i_booth_kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_booth_valid && o_booth_ready) begin
            op_d    = op_in;
            word_d  = word_in;
            acc_d   = '0;
            guard_d = 1'b0;
            if (word_in) begin
              mcand_d = {{(OPW-32){i_booth_rs1[31]}}, i_booth_rs1[31:0]};
              mplr_d  = {{(OPW-32){i_booth_rs2[31]}}, i_booth_rs2[31:0]};
              cnt_d   = CNT_W'(WORD_ITERS);
            end else begin
              mcand_d = {{2{rs1_signed & i_booth_rs1[XLEN-1]}}, i_booth_rs1};
              mplr_d  = {{2{rs2_signed & i_booth_rs2[XLEN-1]}}, i_booth_rs2};
              cnt_d   = CNT_W'(FULL_ITERS);
            end
            state_d = ST_CALC;
          end
        end
        ST_CALC: begin
          if (cnt_q != '0) begin
            acc_d   = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
            mplr_d  = {sum[1:0], mplr_q[OPW-1:2]};
            guard_d = mplr_q[1];
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            result_d = result_sel;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_booth_res_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_booth_clk or negedge i_booth_rstn) begin
    if (!i_booth_rstn) begin
      state_q  <= ST_IDLE;
      alive_q  <= 1'b0;
      op_q     <= MUL_OP_MUL;
      word_q   <= 1'b0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      guard_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      alive_q  <= alive_d;
      op_q     <= op_d;
      word_q   <= word_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      guard_q  <= guard_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
